fp16_to_int_converter: RTL and testbench

- Multi-cycle converter from IEEE-754 half precision (1/5/10, bias 15) to a signed two's-complement integer.
- Rounds toward zero, matching C cast semantics. Saturates on overflow and reports invalid/inexact flags.
- Sits downstream of the FP16 adder/subtractor to hand results to integer datapaths.
- Valid/ready on both sides. Single iterative one-bit shifter, no barrel shifter.

---
 rtl/fp16_to_int_converter.sv | 181 ++++++++++++++++++
 tb/tb_fp16_to_int_converter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fp16_to_int_converter.sv
`default_nettype none
// ============================================================================
// Module      : fp16_to_int_converter
// Description : Iterative FP16 -> signed integer converter, round toward zero,
//               saturating, with invalid/inexact flags and valid/ready ports.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_to_int_converter #(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      fp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] int_out,
  output logic             flag_invalid,
  output logic             flag_inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Biased exponent at which the unbiased exponent reaches INT_W-1
  localparam logic [6:0]     c_LIMIT_E = 7'(INT_W + 14);
  localparam logic [INT_W:0] c_POS_MAX = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0] c_NEG_MIN = {2'b01, {(INT_W-1){1'b0}}};

  state_t           r_state;
  state_t           w_nextState;
  logic [INT_W:0]   r_acc;
  logic [3:0]       r_cnt;
  logic             r_shiftLeft;
  logic             r_sign;
  logic             r_sat;
  logic [INT_W-1:0] r_intOut;
  logic             r_flagInvalid;
  logic             r_flagInexact;
  logic             r_outValid;

  logic             w_sign;
  logic [4:0]       w_exp;
  logic [9:0]       w_man;
  logic             w_accept;
  logic             w_isNan;
  logic             w_isInf;
  logic             w_isZero;
  logic             w_exactMin;
  logic             w_isOvf;
  logic             w_isSat;
  logic [3:0]       w_cnt;
  logic [INT_W-1:0] w_mag;
  logic [INT_W-1:0] w_neg;

  assign w_sign     = fp_in[15];
  assign w_exp      = fp_in[14:10];
  assign w_man      = fp_in[9:0];
  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_isNan    = (w_exp == 5'd31) && (w_man != 10'd0);
  assign w_isInf    = (w_exp == 5'd31) && (w_man == 10'd0);
  assign w_isZero   = (w_exp == 5'd0);
  assign w_exactMin = w_sign && (w_man == 10'd0) && ({2'b00, w_exp} == c_LIMIT_E);
  assign w_isOvf    = (w_exp != 5'd31) && !w_isZero &&
                      ({2'b00, w_exp} >= c_LIMIT_E) && !w_exactMin;
  assign w_isSat    = w_isInf || w_isOvf;

  // Left by e-10 when e>=10, otherwise right by 10-e capped at 11
  always_comb begin
    w_cnt = 4'd11;
    if (w_exp >= 5'd25)
      w_cnt = 4'(w_exp - 5'd25);
    else if (w_exp >= 5'd15)
      w_cnt = 4'(5'd25 - w_exp);
  end

  assign w_mag = r_acc[INT_W-1:0];
  assign w_neg = ~w_mag + {{(INT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isNan || w_isSat || w_isZero)
            w_nextState = SIGN;
          else
            w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == 4'd0)
          w_nextState = SIGN;
      end
      SIGN:    w_nextState = DONE;
      DONE: begin
        if (r_outValid && out_ready)
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_cnt         <= 4'd0;
      r_shiftLeft   <= 1'b0;
      r_sign        <= 1'b0;
      r_sat         <= 1'b0;
      r_intOut      <= '0;
      r_flagInvalid <= 1'b0;
      r_flagInexact <= 1'b0;
      r_outValid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_flagInvalid <= w_isNan || w_isSat;
            r_flagInexact <= w_isZero && (w_man != 10'd0);
            r_sign        <= w_sign && !w_isNan && !w_isZero;
            r_sat         <= w_isSat;
            r_shiftLeft   <= (w_exp >= 5'd25);
            r_cnt         <= w_cnt;
            if (w_isSat)
              r_acc <= w_sign ? c_NEG_MIN : c_POS_MAX;
            else if (w_isNan || w_isZero)
              r_acc <= '0;
            else
              r_acc <= {{(INT_W-10){1'b0}}, 1'b1, w_man};
          end
        end
        SHIFT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_shiftLeft) begin
              r_acc <= {r_acc[INT_W-1:0], 1'b0};
            end else begin
              r_acc         <= {1'b0, r_acc[INT_W:1]};
              r_flagInexact <= r_flagInexact | r_acc[0];
            end
          end
        end
        SIGN: begin
          if (r_sat)
            r_intOut <= w_mag;
          else
            r_intOut <= r_sign ? w_neg : w_mag;
        end
        DONE: begin
          // Result register settles one cycle before it is advertised
          if (!r_outValid)
            r_outValid <= 1'b1;
          else if (out_ready)
            r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_outValid;
  assign int_out      = r_intOut;
  assign flag_invalid = r_flagInvalid;
  assign flag_inexact = r_flagInexact;

endmodule
`default_nettype wire

// File: tb/tb_fp16_to_int_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_to_int_converter
// Description : Directed-vector bench for fp16_to_int_converter (INT_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_to_int_converter;

  localparam int INT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      fp_in;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] int_out;
  logic             flag_invalid;
  logic             flag_inexact;

  int checkCount = 0;
  int errorCount = 0;

  fp16_to_int_converter #(.INT_W(INT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fp_in        (fp_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .int_out      (int_out),
    .flag_invalid (flag_invalid),
    .flag_inexact (flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called just after the accept edge; counts edges until out_valid.
  task automatic waitResult(input string tag, input logic [15:0] expInt,
                            input logic expInv, input logic expInex,
                            input int expLat);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkValue({tag, ".lat"}, 32'(lat), 32'(expLat));
    checkValue({tag, ".int"}, 32'(int_out), 32'(expInt));
    checkValue({tag, ".inv"}, 32'(flag_invalid), 32'(expInv));
    checkValue({tag, ".inex"}, 32'(flag_inexact), 32'(expInex));
  endtask

  task automatic convert(input string tag, input logic [15:0] fp,
                         input logic [15:0] expInt, input logic expInv,
                         input logic expInex, input int expLat);
    @(negedge clk);
    fp_in    = fp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fp_in    = 16'h7E00;  // later operand changes must be ignored
    waitResult(tag, expInt, expInv, expInex, expLat);
    @(posedge clk); #1;
  endtask

  initial begin
    bit sawValid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    fp_in     = 16'h0000;
    out_ready = 1'b1;
    #1;
    checkValue("rst.in_ready", 32'(in_ready), 32'd1);
    checkValue("rst.out_valid", 32'(out_valid), 32'd0);
    checkValue("rst.int_out", 32'(int_out), 32'd0);
    checkValue("rst.flags", 32'({flag_invalid, flag_inexact}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    convert("one",     16'h3C00, 16'h0001, 1'b0, 1'b0, 13);
    convert("negzero", 16'h8000, 16'h0000, 1'b0, 1'b0, 2);
    convert("neg10",   16'hC900, 16'hFFF6, 1'b0, 1'b0, 10);
    convert("p1_5",    16'h3E00, 16'h0001, 1'b0, 1'b1, 13);
    convert("n1_5",    16'hBE00, 16'hFFFF, 1'b0, 1'b1, 13);
    convert("v125",    16'h57D0, 16'h007D, 1'b0, 1'b0, 7);
    convert("p32768",  16'h7800, 16'h7FFF, 1'b1, 1'b0, 2);
    convert("n32768",  16'hF800, 16'h8000, 1'b0, 1'b0, 8);
    convert("p65504",  16'h7BFF, 16'h7FFF, 1'b1, 1'b0, 2);
    convert("pinf",    16'h7C00, 16'h7FFF, 1'b1, 1'b0, 2);
    convert("ninf",    16'hFC00, 16'h8000, 1'b1, 1'b0, 2);
    convert("nan",     16'h7E00, 16'h0000, 1'b1, 1'b0, 2);
    convert("subnorm", 16'h0001, 16'h0000, 1'b0, 1'b1, 2);
    convert("quarter", 16'h3400, 16'h0000, 1'b0, 1'b1, 14);

    // Backpressure: result held, second operand refused until handshake
    out_ready = 1'b0;
    @(negedge clk);
    fp_in    = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult("bp", 16'h0002, 1'b0, 1'b0, 12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fp_in    = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checkValue("bp.hold_valid", 32'(out_valid), 32'd1);
      checkValue("bp.hold_ready", 32'(in_ready), 32'd0);
      checkValue("bp.hold_int", 32'(int_out), 32'h0002);
      checkValue("bp.hold_flags", 32'({flag_invalid, flag_inexact}), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkValue("bp.release_valid", 32'(out_valid), 32'd0);
    checkValue("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult("bp2", 16'h0001, 1'b0, 1'b0, 13);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    fp_in    = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("arst.out_valid", 32'(out_valid), 32'd0);
    checkValue("arst.in_ready", 32'(in_ready), 32'd1);
    checkValue("arst.int_out", 32'(int_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkValue("arst.no_result", 32'(sawValid), 32'd0);
    convert("post_rst", 16'h4000, 16'h0002, 1'b0, 1'b0, 12);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
`default_nettype wire
